hypot_req_scheduler: RTL and testbench

//  Shares one iterative magnitude engine, sqrt(x^2+y^2), between N_REQ requesters.

---
 rtl/hypot_req_scheduler.sv | 174 +++++++++++++++++
 tb/tb_hypot_req_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hypot_req_scheduler.sv
// -----------------------------------------------------------------------------
// hypot_req_scheduler
//
// Shares one iterative magnitude engine, sqrt(x^2+y^2), between N_REQ
// requesters. A round-robin arbiter picks a requester in IDLE, its operands are
// latched onto the engine inputs, the engine is started once it is not busy,
// and the scheduler waits for eng_done or a watchdog timeout before returning
// the result to the granted requester.
//
// Ports
//   clk          in   1              rising-edge clock
//   rst          in   1              synchronous active-high reset
//   req_valid    in   N_REQ          per-requester request level
//   req_x        in   N_REQ*DW       packed x operands, requester i at [i*DW +: DW]
//   req_y        in   N_REQ*DW       packed y operands, same packing
//   req_ready    out  N_REQ          one-hot, 1-cycle accept pulse
//   rsp_valid    out  N_REQ          one-hot, 1-cycle response pulse
//   rsp_data     out  RW             result, held until the next response
//   rsp_timeout  out  1              response was produced by the watchdog
//   eng_start    out  1              1-cycle engine start pulse
//   eng_x/eng_y  out  DW             latched operands, stable start..done
//   eng_busy     in   1              engine busy, start is deferred
//   eng_done     in   1              1-cycle engine completion pulse
//   eng_result   in   RW             engine result, valid with eng_done
//   cur_owner    out  clog2(N_REQ)   current or last granted requester
//   idle         out  1              FSM is in IDLE
// -----------------------------------------------------------------------------
module hypot_req_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int RW      = 9,
  parameter int TIMEOUT = 64,
  localparam int OW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int TW     = $clog2(TIMEOUT) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_x,
  input  logic [N_REQ*DW-1:0] req_y,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [RW-1:0]       rsp_data,
  output logic                rsp_timeout,
  output logic                eng_start,
  output logic [DW-1:0]       eng_x,
  output logic [DW-1:0]       eng_y,
  input  logic                eng_busy,
  input  logic                eng_done,
  input  logic [RW-1:0]       eng_result,
  output logic [OW-1:0]       cur_owner,
  output logic                idle
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [OW-1:0]   last_grant;
  logic [TW-1:0]   timer;

  logic [DW-1:0]   lane_x [N_REQ];
  logic [DW-1:0]   lane_y [N_REQ];

  logic            any_req;
  logic [OW-1:0]   gnt_idx;
  int unsigned     cand;
  logic [OW-1:0]   cand_idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_x[g] = req_x[g*DW +: DW];
    assign lane_y[g] = req_y[g*DW +: DW];
  end

  // Round-robin search: candidates last_grant+1 .. last_grant+N_REQ, wrapped,
  // first requesting one wins. last_grant resets to N_REQ-1 so 0 goes first.
  always_comb begin
    any_req  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= NR) begin
        cand = cand - NR;
      end
      cand_idx = cand[OW-1:0];
      if (!any_req && req_valid[cand_idx]) begin
        any_req = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      eng_start   <= 1'b0;
      eng_x       <= '0;
      eng_y       <= '0;
      cur_owner   <= '0;
      timer       <= '0;
      idle        <= 1'b1;
      last_grant  <= OW'(N_REQ - 1);
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            req_ready <= onehot(gnt_idx);
            eng_x     <= lane_x[gnt_idx];
            eng_y     <= lane_y[gnt_idx];
            cur_owner <= gnt_idx;
            idle      <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!eng_busy) begin
            eng_start <= 1'b1;
            timer     <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // rsp_valid is raised on the way into RESP so it is high exactly
          // during the RESP cycle; done takes precedence over the watchdog.
          if (eng_done) begin
            rsp_data    <= eng_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= onehot(cur_owner);
            state       <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= onehot(cur_owner);
            state       <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          last_grant <= cur_owner;
          idle       <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          idle  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_req_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for hypot_req_scheduler: a 5-cycle isqrt engine model, directed steps
// in one initial block, expected responses queued when stimulus is driven and
// popped when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_hypot_req_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_x = '0;
  logic [N*DW-1:0] req_y = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [RW-1:0]   rsp_data;
  logic            rsp_timeout;
  logic            eng_start;
  logic [DW-1:0]   eng_x;
  logic [DW-1:0]   eng_y;
  logic            eng_busy = 1'b0;
  logic            eng_done;
  logic [RW-1:0]   eng_result;
  logic [1:0]      cur_owner;
  logic            idle;

  hypot_req_scheduler #(.N_REQ(N), .DW(DW), .RW(RW), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_busy   (eng_busy),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .cur_owner  (cur_owner),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Engine model: fixed 5-cycle latency from eng_start to eng_done.
  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  logic          never_done = 1'b0;
  logic [4:0]    pv = '0;
  logic [RW-1:0] pr [5];

  always @(posedge clk) begin
    pv    <= {pv[3:0], eng_start};
    pr[0] <= RW'(isqrt(int'(eng_x) * int'(eng_x) + int'(eng_y) * int'(eng_y)));
    for (int i = 1; i < 5; i++) pr[i] <= pr[i-1];
  end

  assign eng_done   = pv[4] & ~never_done;
  assign eng_result = pr[4];

  typedef struct {
    int owner;
    int data;
    int tmo;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int owner, input int data, input int tmo);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    e.tmo   = tmo;
    sb.push_back(e);
  endtask

  task automatic set_lane(input int i, input int x, input int y);
    req_x[i*DW +: DW] = DW'(x);
    req_y[i*DW +: DW] = DW'(y);
  endtask

  task automatic wait_grant(input string tag, output int g);
    logic found;
    found = 1'b0;
    g = -1;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (req_ready != '0) begin
        found = 1'b1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        chk({tag, "_ready_onehot"}, $countones(req_ready), 1);
      end
    end
    chk({tag, "_grant_seen"}, found, 1);
  endtask

  task automatic wait_rsp(input string tag, output int cyc);
    logic found;
    found = 1'b0;
    cyc = 0;
    while (cyc < 200 && !found) begin
      tick();
      cyc++;
      if (rsp_valid != '0) found = 1'b1;
    end
    chk({tag, "_rsp_seen"}, found, 1);
  endtask

  task automatic take_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, rsp_valid, 32'(1) << e.owner);
      chk({tag, "_rsp_data"}, rsp_data, e.data);
      chk({tag, "_rsp_timeout"}, rsp_timeout, e.tmo);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_x"}, eng_x, 0);
    chk({tag, "_eng_y"}, eng_y, 0);
    chk({tag, "_cur_owner"}, cur_owner, 0);
    chk({tag, "_idle"}, idle, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("rst");
    rst = 1'b0;
  endtask

  initial begin
    int g;
    int cyc;
    int viol;
    int ord [4] = '{0, 2, 0, 2};
    int t2_data [4] = '{5, 25, 18, 10};
    int t3_data [4] = '{13, 15, 13, 15};

    do_reset();

    // 1: single request, 7 cycles from req_ready to rsp_valid
    set_lane(0, 3, 4);
    req_valid = 4'b0001;
    push_exp(0, 5, 0);
    wait_grant("t1", g);
    chk("t1_grant", g, 0);
    chk("t1_eng_x", eng_x, 3);
    chk("t1_eng_y", eng_y, 4);
    chk("t1_owner", cur_owner, 0);
    req_valid = '0;
    wait_rsp("t1", cyc);
    chk("t1_latency", cyc, 7);
    take_rsp("t1");
    tick();
    chk("t1_rsp_pulse_1cyc", rsp_valid, 0);
    chk("t1_rsp_data_hold", rsp_data, 5);

    // 2: all four at once after reset, served 0,1,2,3
    do_reset();
    set_lane(0, 3, 4);
    set_lane(1, 7, 24);
    set_lane(2, 10, 15);
    set_lane(3, 8, 6);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) push_exp(i, t2_data[i], 0);
    for (int i = 0; i < 4; i++) begin
      wait_grant("t2", g);
      chk("t2_grant", g, i);
      if (g >= 0) req_valid[g] = 1'b0;
      wait_rsp("t2", cyc);
      chk("t2_latency", cyc, 7);
      take_rsp("t2");
    end

    // 3: req0 and req2 held continuously alternate
    set_lane(0, 5, 12);
    set_lane(2, 9, 12);
    req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) push_exp(ord[i], t3_data[i], 0);
    for (int i = 0; i < 4; i++) begin
      wait_grant("t3", g);
      chk("t3_grant", g, ord[i]);
      if (i == 3) req_valid = '0;
      wait_rsp("t3", cyc);
      take_rsp("t3");
    end

    // 4: busy engine defers eng_start
    eng_busy = 1'b1;
    set_lane(0, 20, 21);
    req_valid = 4'b0001;
    push_exp(0, 29, 0);
    wait_grant("t4", g);
    chk("t4_grant", g, 0);
    req_valid = '0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eng_start !== 1'b0) viol++;
    end
    chk("t4_no_start_while_busy", viol, 0);
    eng_busy = 1'b0;
    tick();
    chk("t4_start_after_busy", eng_start, 1);
    wait_rsp("t4", cyc);
    chk("t4_latency_from_start", cyc, 6);
    chk("t4_eng_x_stable", eng_x, 20);
    take_rsp("t4");

    // 5: engine never completes, watchdog after 64 cycles
    never_done = 1'b1;
    set_lane(1, 1, 1);
    req_valid = 4'b0010;
    push_exp(1, 0, 1);
    wait_grant("t5", g);
    chk("t5_grant", g, 1);
    req_valid = '0;
    tick();
    chk("t5_start", eng_start, 1);
    wait_rsp("t5", cyc);
    chk("t5_timeout_cycles", cyc, 64);
    take_rsp("t5");
    tick();
    chk("t5_timeout_hold", rsp_timeout, 1);
    never_done = 1'b0;

    // 6: reset while waiting, the late done is ignored
    set_lane(3, 30, 40);
    req_valid = 4'b1000;
    wait_grant("t6", g);
    chk("t6_grant", g, 3);
    req_valid = '0;
    tick();
    chk("t6_start", eng_start, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_state("t6_rst");
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== '0 || idle !== 1'b1) viol++;
    end
    chk("t6_no_rsp_after_abort", viol, 0);
    set_lane(0, 6, 8);
    set_lane(2, 9, 12);
    req_valid = 4'b0101;
    push_exp(0, 10, 0);
    wait_grant("t6b", g);
    chk("t6b_grant_req0", g, 0);
    req_valid = '0;
    wait_rsp("t6b", cyc);
    take_rsp("t6b");

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
